bus_watchdog_ctrl: RTL and testbench

Timer and recovery sequencer for the core's bus watchdog. It tracks outstanding transactions on the core data bus and counts cycles without bus progress. When the programmed timeout expires, it aborts the stalled transfer and returns error responses for every transaction still pending. Enable and timeout value come from the watchdog CSR block, and the sticky timeout status feeds back to that block's status register.

---
 rtl/bus_watchdog_ctrl_if.sv | 31 +++
 rtl/bus_watchdog_ctrl.sv | 139 +++++++++++++
 tb/tb_bus_watchdog_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_watchdog_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bus_watchdog_ctrl_if                                            |
// | Brief    : Core data-bus handshake seen by the watchdog, with its abort and |
// |            synthesized error-response returns.                             |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface bus_watchdog_ctrl_if;
  logic bus_req_i;
  logic bus_gnt_i;
  logic bus_rvalid_i;
  logic abort_o;
  logic err_rvalid_o;

  modport master (
    output bus_req_i,
    output bus_gnt_i,
    output bus_rvalid_i,
    input  abort_o,
    input  err_rvalid_o
  );

  modport slave (
    input  bus_req_i,
    input  bus_gnt_i,
    input  bus_rvalid_i,
    output abort_o,
    output err_rvalid_o
  );
endinterface
`default_nettype wire

// File: rtl/bus_watchdog_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bus_watchdog_ctrl                                               |
// | Brief    : Bus stall timer; on expiry aborts the fabric transfer and       |
// |            flushes pending transactions. Option macro: WDT_ERR_RSP_EN.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module bus_watchdog_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_OUTST  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wdt_enable_i,
  input  logic [DATA_WIDTH-1:0] timeout_value_i,
  input  logic                  status_clr_i,
  bus_watchdog_ctrl_if.slave    bus_if,
  output logic                  timeout_status_o,
  output logic                  timeout_irq_o
);
  localparam int              c_OW        = $clog2(MAX_OUTST + 1);
  localparam logic [c_OW-1:0] c_OUTST_MAX = c_OW'(MAX_OUTST);
  localparam logic [c_OW-1:0] c_OUTST_ONE = c_OW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [c_OW-1:0]       r_outst, w_outst_nxt;
  logic                  r_abort, r_status, r_irq;
  logic                  w_accept, w_pending, w_progress, w_stay_armed;
  logic                  w_limit_hit, w_expire;
  logic [DATA_WIDTH-1:0] w_limit;

  assign w_accept     = bus_if.bus_req_i && bus_if.bus_gnt_i;
  assign w_pending    = (r_outst != '0) || (bus_if.bus_req_i && !bus_if.bus_gnt_i);
  assign w_progress   = w_accept || bus_if.bus_rvalid_i;
  assign w_stay_armed = wdt_enable_i && w_pending && (timeout_value_i != '0);
  // >= rather than == so a live-lowered timeout below cnt still expires
  assign w_limit      = timeout_value_i - DATA_WIDTH'(1);
  assign w_limit_hit  = (r_cnt >= w_limit);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_outst_nxt = r_outst;
    w_expire    = 1'b0;

    if (w_accept && !bus_if.bus_rvalid_i && (r_outst != c_OUTST_MAX)) begin
      w_outst_nxt = r_outst + c_OUTST_ONE;
    end else if (!w_accept && bus_if.bus_rvalid_i && (r_outst != '0)) begin
      w_outst_nxt = r_outst - c_OUTST_ONE;
    end

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_stay_armed) begin
          w_state_nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        if (!w_stay_armed) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_progress) begin
          w_cnt_nxt = '0;
        end else if (w_limit_hit) begin
          w_expire    = 1'b1;
          w_state_nxt = S_FLUSH;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + DATA_WIDTH'(1);
        end
      end
      S_FLUSH: begin
        // Bus inputs are ignored here; only the flush drains the count.
        w_cnt_nxt = '0;
`ifdef WDT_ERR_RSP_EN
        w_outst_nxt = (r_outst != '0) ? (r_outst - c_OUTST_ONE) : r_outst;
        if (r_outst <= c_OUTST_ONE) begin
          w_state_nxt = S_IDLE;
        end
`else
        w_outst_nxt = '0;
        w_state_nxt = S_IDLE;
`endif
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_outst  <= '0;
      r_abort  <= 1'b0;
      r_irq    <= 1'b0;
      r_status <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_outst  <= w_outst_nxt;
      r_abort  <= (w_state_nxt == S_FLUSH);
      r_irq    <= w_expire;
      r_status <= w_expire || (r_status && !status_clr_i);
    end
  end

`ifdef WDT_ERR_RSP_EN
  logic r_err;

  // One error response per FLUSH cycle that still has a granted transaction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (w_state_nxt == S_FLUSH) && (w_outst_nxt != '0);
    end
  end

  assign bus_if.err_rvalid_o = r_err;
`else
  assign bus_if.err_rvalid_o = 1'b0;
`endif

  assign bus_if.abort_o   = r_abort;
  assign timeout_irq_o    = r_irq;
  assign timeout_status_o = r_status;
endmodule
`default_nettype wire

// File: tb/tb_bus_watchdog_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_bus_watchdog_ctrl                                            |
// | Brief    : Directed bench for bus_watchdog_ctrl with a cycle-level model.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_bus_watchdog_ctrl;
  localparam int DW = 32;
  localparam int MO = 4;
`ifdef WDT_ERR_RSP_EN
  localparam bit ERR_MODE = 1'b1;
`else
  localparam bit ERR_MODE = 1'b0;
`endif

  logic          clk_i  = 1'b0;
  logic          rst_ni = 1'b0;
  logic          en     = 1'b0;
  logic          clr    = 1'b0;
  logic [DW-1:0] tv     = '0;
  logic          status, irq;

  bus_watchdog_ctrl_if bus_if ();

  bus_watchdog_ctrl #(.DATA_WIDTH(DW), .MAX_OUTST(MO)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .wdt_enable_i     (en),
    .timeout_value_i  (tv),
    .status_clr_i     (clr),
    .bus_if           (bus_if),
    .timeout_status_o (status),
    .timeout_irq_o    (irq)
  );

  always #5 clk_i = ~clk_i;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: outstanding count, stall length while watching, flush cycles left.
  int m_outst, m_stall, m_flush;
  bit m_watch, e_abort, e_err, e_irq, e_status;

  task automatic model_step();
    bit req, gnt, rv, acc, prog, pend;
    req  = bus_if.bus_req_i;
    gnt  = bus_if.bus_gnt_i;
    rv   = bus_if.bus_rvalid_i;
    acc  = req && gnt;
    prog = acc || rv;
    pend = (m_outst != 0) || (req && !gnt);
    e_irq = 1'b0;
    if (m_flush > 0) begin
      if (ERR_MODE) begin
        if (m_outst > 0) m_outst--;
        m_flush--;
      end else begin
        m_outst = 0;
        m_flush = 0;
      end
    end else begin
      if (acc && !rv) m_outst = (m_outst < MO) ? m_outst + 1 : MO;
      else if (rv && !acc && m_outst > 0) m_outst--;
      if (m_watch) begin
        if (!pend || !en || tv == 0) m_watch = 1'b0;
        else if (prog) m_stall = 0;
        else if (longint'(m_stall) + 1 >= longint'(tv)) begin
          m_watch = 1'b0;
          e_irq   = 1'b1;
          m_flush = (ERR_MODE && m_outst > 0) ? m_outst : 1;
        end else m_stall++;
      end else if (en && pend && tv != 0) begin
        m_watch = 1'b1;
        m_stall = 0;
      end
    end
    if (e_irq) e_status = 1'b1;
    else if (clr) e_status = 1'b0;
    e_abort = (m_flush > 0);
    e_err   = ERR_MODE && (m_flush > 0) && (m_outst > 0);
  endtask

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_outst = 0; m_stall = 0; m_flush = 0; m_watch = 1'b0;
      e_abort = 1'b0; e_err = 1'b0; e_irq = 1'b0; e_status = 1'b0;
    end else begin
      model_step();
    end
  end

  always @(posedge clk_i) begin
    #1;
    if (rst_ni) begin
      chk("cyc_abort",  bus_if.abort_o,      e_abort);
      chk("cyc_err",    bus_if.err_rvalid_o, e_err);
      chk("cyc_irq",    irq,                 e_irq);
      chk("cyc_status", status,              e_status);
    end
  end

  task automatic drive(input bit r, input bit g, input bit v);
    bus_if.bus_req_i    = r;
    bus_if.bus_gnt_i    = g;
    bus_if.bus_rvalid_i = v;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    drive(0, 0, 0);
    en  = 1'b0;
    clr = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // Cycles (negedges) until abort_o is seen; 0 if it never rises within limit.
  task automatic wait_abort(input int limit, output int cyc);
    cyc = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk_i);
      if (bus_if.abort_o === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n_ab, n_err, first, cyc;
    drive(0, 0, 0);
    repeat (3) @(negedge clk_i);
    chk("rst_abort",  bus_if.abort_o,      0);
    chk("rst_err",    bus_if.err_rvalid_o, 0);
    chk("rst_irq",    irq,                 0);
    chk("rst_status", status,              0);
    rst_ni = 1'b1;

    // Stalled ungranted request, timeout 4.
    en = 1'b1; tv = 4; drive(1, 0, 0);
    n_ab = 0;
    repeat (4) begin
      @(negedge clk_i);
      if (bus_if.abort_o) n_ab++;
    end
    chk("t1_early_abort", n_ab, 0);
    @(negedge clk_i);
    chk("t1_abort",  bus_if.abort_o,      1);
    chk("t1_irq",    irq,                 1);
    chk("t1_status", status,              1);
    chk("t1_err",    bus_if.err_rvalid_o, 0);
    drive(0, 0, 0);
    @(negedge clk_i);
    chk("t1_abort_end", bus_if.abort_o, 0);
    chk("t1_irq_pulse", irq,            0);
    chk("t1_sticky",    status,         1);
    clr = 1'b1; @(negedge clk_i); clr = 1'b0;
    chk("t1_clear", status, 0);

    // Three granted transactions never answered, timeout 8.
    do_reset();
    en = 1'b1; tv = 8; drive(1, 1, 0);
    repeat (3) @(negedge clk_i);
    drive(0, 0, 0);
    n_ab = 0; n_err = 0; first = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk_i);
      if (bus_if.abort_o) begin
        n_ab++;
        if (first == 0) first = i;
      end
      if (bus_if.err_rvalid_o) n_err++;
    end
    chk("t2_first_abort", first, 8);
    chk("t2_abort_cycles", n_ab, ERR_MODE ? 3 : 1);
    chk("t2_err_pulses",  n_err, ERR_MODE ? 3 : 0);

    // Grant every 4 cycles keeps a timeout of 5 from expiring.
    do_reset();
    en = 1'b1; tv = 5;
    n_ab = 0;
    for (int i = 0; i < 100; i++) begin
      drive(1, (i % 4) == 3, 0);
      @(negedge clk_i);
      if (bus_if.abort_o) n_ab++;
    end
    chk("t3_no_abort",  n_ab,   0);
    chk("t3_status_lo", status, 0);

    // Disable with cnt=3, then re-enable restarts the count.
    do_reset();
    en = 1'b1; tv = 10; drive(1, 0, 0);
    repeat (4) @(negedge clk_i);
    en = 1'b0;
    n_ab = 0;
    repeat (6) begin
      @(negedge clk_i);
      if (bus_if.abort_o) n_ab++;
    end
    chk("t4_disabled_no_abort", n_ab, 0);
    en = 1'b1;
    wait_abort(40, cyc);
    chk("t4_restart_latency", cyc, 11);
    drive(0, 0, 0);

    // Expiry coinciding with a status clear: set wins.
    do_reset();
    en = 1'b1; tv = 4; drive(1, 0, 0);
    repeat (4) @(negedge clk_i);
    clr = 1'b1; @(negedge clk_i); clr = 1'b0;
    chk("t5_abort",      bus_if.abort_o, 1);
    chk("t5_set_wins",   status,         1);
    drive(0, 0, 0);
    repeat (3) @(negedge clk_i);
    chk("t5_still_set",  status, 1);
    clr = 1'b1; @(negedge clk_i); clr = 1'b0;
    chk("t5_cleared",    status, 0);

    // Reset in the middle of a flush with two outstanding.
    do_reset();
    en = 1'b1; tv = 3; drive(1, 1, 0);
    repeat (2) @(negedge clk_i);
    drive(0, 0, 0);
    wait_abort(20, cyc);
    chk("t6_reached_flush", cyc != 0, 1);
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_abort",  bus_if.abort_o,      0);
    chk("t6_rst_err",    bus_if.err_rvalid_o, 0);
    chk("t6_rst_irq",    irq,                 0);
    chk("t6_rst_status", status,              0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    wait_abort(10, cyc);
    chk("t6_outst_cleared", cyc, 0);
    drive(1, 0, 0);
    wait_abort(20, cyc);
    chk("t6_fresh_latency", cyc, 4);
    drive(0, 0, 0);

    // Lowering the timeout below the running count expires at once.
    do_reset();
    en = 1'b1; tv = 20; drive(1, 0, 0);
    repeat (7) @(negedge clk_i);
    tv = 3;
    @(negedge clk_i);
    chk("t7_lowered_abort", bus_if.abort_o, 1);
    chk("t7_lowered_irq",   irq,            1);
    drive(0, 0, 0);

    // Stray responses are ignored; one real grant then stall.
    do_reset();
    drive(0, 0, 1);
    repeat (3) @(negedge clk_i);
    drive(1, 1, 0);
    @(negedge clk_i);
    drive(0, 0, 0);
    en = 1'b1; tv = 6;
    n_ab = 0; n_err = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (bus_if.abort_o) n_ab++;
      if (bus_if.err_rvalid_o) n_err++;
    end
    chk("t8_abort_cycles", n_ab, 1);
    chk("t8_err_pulses",  n_err, ERR_MODE ? 1 : 0);

    repeat (2) @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
`default_nettype wire
